// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sharing one 32-bit ALU
// Holds one op in flight: grant latches operands, EXEC computes, RESP holds the result.
module alu_arbiter #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 4,
  parameter int MAX_CTRL = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [4:0]        req0_shamt_i,
  input  logic [CTRL_W-1:0] req0_aluctr_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [DATA_W-1:0] rsp0_result_o,
  output logic              rsp0_err_o,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  input  logic [4:0]        req1_shamt_i,
  input  logic [CTRL_W-1:0] req1_aluctr_i,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp1_result_o,
  output logic              rsp1_err_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e              state_q, state_d;
  logic                rr_ptr_q;
  logic                owner_q;
  logic [DATA_W-1:0]   op_a_q, op_b_q;
  logic [4:0]          op_shamt_q;
  logic [CTRL_W-1:0]   op_ctr_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic                rsp_err_q;

  logic                rsp_hs, grant_window, grant, winner;
  logic [DATA_W-1:0]   alu_res;
  logic                op_err;

  function automatic logic [DATA_W-1:0] clz(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] n;
    n = DATA_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (v[i]) n = DATA_W'(DATA_W - 1 - i);
    end
    return n;
  endfunction

  always_comb begin
    rsp_hs       = (state_q == RESP) && (owner_q ? rsp1_ready_i : rsp0_ready_i);
    grant_window = (state_q == IDLE) || rsp_hs;
    // rr_ptr_q holds the last winner, so on a tie the other port goes next
    winner       = req1_valid_i && (!req0_valid_i || !rr_ptr_q);
    grant        = grant_window && (req0_valid_i || req1_valid_i);
    req0_ready_o = grant && !winner;
    req1_ready_o = grant && winner;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = grant ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op_ctr_q)
      CTRL_W'(0): alu_res = op_a_q + op_b_q;
      CTRL_W'(1): alu_res = op_a_q - op_b_q;
      CTRL_W'(2): alu_res = op_a_q | op_b_q;
      CTRL_W'(3): alu_res = clz(op_a_q);
      // a shift by the full width yields zero, which makes shamt=0 return b
      CTRL_W'(4): alu_res = (op_b_q >> op_shamt_q) | (op_b_q << (6'(DATA_W) - {1'b0, op_shamt_q}));
      default:    alu_res = '0;
    endcase
    op_err = op_ctr_q > CTRL_W'(MAX_CTRL);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b1;
      owner_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_shamt_q   <= '0;
      op_ctr_q     <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        op_a_q     <= winner ? req1_a_i      : req0_a_i;
        op_b_q     <= winner ? req1_b_i      : req0_b_i;
        op_shamt_q <= winner ? req1_shamt_i  : req0_shamt_i;
        op_ctr_q   <= winner ? req1_aluctr_i : req0_aluctr_i;
        owner_q    <= winner;
        rr_ptr_q   <= winner;
      end
      if (state_q == EXEC) begin
        rsp_result_q <= op_err ? '0 : alu_res;
        rsp_err_q    <= op_err;
      end
    end
  end

  always_comb begin
    rsp0_valid_o  = (state_q == RESP) && !owner_q;
    rsp1_valid_o  = (state_q == RESP) && owner_q;
    rsp0_result_o = rsp0_valid_o ? rsp_result_q : '0;
    rsp1_result_o = rsp1_valid_o ? rsp_result_q : '0;
    rsp0_err_o    = rsp0_valid_o && rsp_err_q;
    rsp1_err_o    = rsp1_valid_o && rsp_err_q;
    busy_o        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_a     [2];
  logic [31:0] req_b     [2];
  logic [4:0]  req_shamt [2];
  logic [3:0]  req_ctr   [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_result[2];
  logic        rsp_err   [2];
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32), .CTRL_W(4), .MAX_CTRL(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req_valid[0]), .req0_ready_o(req_ready[0]),
    .req0_a_i(req_a[0]), .req0_b_i(req_b[0]), .req0_shamt_i(req_shamt[0]), .req0_aluctr_i(req_ctr[0]),
    .rsp0_valid_o(rsp_valid[0]), .rsp0_ready_i(rsp_ready[0]),
    .rsp0_result_o(rsp_result[0]), .rsp0_err_o(rsp_err[0]),
    .req1_valid_i(req_valid[1]), .req1_ready_o(req_ready[1]),
    .req1_a_i(req_a[1]), .req1_b_i(req_b[1]), .req1_shamt_i(req_shamt[1]), .req1_aluctr_i(req_ctr[1]),
    .rsp1_valid_o(rsp_valid[1]), .rsp1_ready_i(rsp_ready[1]),
    .rsp1_result_o(rsp_result[1]), .rsp1_err_o(rsp_err[1]),
    .busy_o(busy)
  );

  typedef struct {
    int          port;
    logic [3:0]  ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] exp_r;
    logic        exp_e;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Reference ALU written from the operation definitions, bit by bit.
  function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] s);
    logic [31:0] r;
    int n;
    r = 32'h0;
    if (c > 4'd4) return {1'b1, 32'h0};
    case (c)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a | b;
      4'd3: begin
        n = 0;
        while (n < 32 && a[31-n] == 1'b0) n++;
        r = 32'(n);
      end
      default: for (int k = 0; k < 32; k++) r[k] = b[(k + int'(s)) % 32];
    endcase
    return {1'b0, r};
  endfunction

  task automatic set_op(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s);
    req_ctr[p] = c; req_a[p] = a; req_b[p] = b; req_shamt[p] = s;
  endtask

  task automatic do_reset();
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b0; rsp_ready[p] = 1'b1; set_op(p, 4'd0, 32'h0, 32'h0, 5'd0);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin ok = 1'b1; return; end
    end
  endtask

  task automatic run_op(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, input logic [31:0] er, input logic ee, input string nm);
    bit ok;
    set_op(p, c, a, b, s);
    req_valid[p] = 1'b1;
    wait_ready(p, ok);
    chk({nm, "_grant"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    if (!ok) return;
    @(negedge clk);
    chk({nm, "_lat1"}, 32'(rsp_valid[p]), 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(rsp_valid[p]), 32'd1);
    chk({nm, "_result"}, rsp_result[p], er);
    chk({nm, "_err"}, 32'(rsp_err[p]), 32'(ee));
    @(posedge clk); #1;
  endtask

  logic [32:0] q0 [$];
  logic [32:0] q1 [$];

  task automatic rand_op(input int p);
    logic [3:0] c;
    logic [31:0] a;
    c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
    a = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
    set_op(p, c, a, $urandom, 5'($urandom_range(0, 31)));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int g [$];
    int rc [$];
    bit acc [2];
    logic [32:0] e;
    int cyc;

    tbl[0]  = '{0, 4'd0, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0};
    tbl[1]  = '{0, 4'd1, 32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, 1'b0};
    tbl[2]  = '{1, 4'd2, 32'hF0F0F0F0, 32'h0F0F0000, 5'd0,  32'hFFFFF0F0, 1'b0};
    tbl[3]  = '{0, 4'd3, 32'h00000000, 32'h12345678, 5'd0,  32'd32,       1'b0};
    tbl[4]  = '{1, 4'd3, 32'h80000000, 32'h0,        5'd0,  32'd0,        1'b0};
    tbl[5]  = '{0, 4'd3, 32'h00000001, 32'h0,        5'd0,  32'd31,       1'b0};
    tbl[6]  = '{1, 4'd4, 32'hDEADBEEF, 32'h12345678, 5'd0,  32'h12345678, 1'b0};
    tbl[7]  = '{1, 4'd4, 32'h0,        32'h00000001, 5'd31, 32'h00000002, 1'b0};
    tbl[8]  = '{1, 4'd7, 32'h11111111, 32'h22222222, 5'd3,  32'h00000000, 1'b1};
    tbl[9]  = '{1, 4'd0, 32'h00000002, 32'h00000003, 5'd0,  32'h00000005, 1'b0};
    tbl[10] = '{0, 4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000000, 1'b1};
    tbl[11] = '{0, 4'd5, 32'h00000004, 32'h00000004, 5'd0,  32'h00000000, 1'b1};
    tbl[12] = '{0, 4'd4, 32'h0,        32'hA5A5A5A5, 5'd16, 32'hA5A5A5A5, 1'b0};

    do_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp0_valid", 32'(rsp_valid[0]), 0);
    chk("rst_rsp1_valid", 32'(rsp_valid[1]), 0);
    chk("rst_rsp0_result", rsp_result[0], 0);
    chk("rst_rsp1_err", 32'(rsp_err[1]), 0);
    chk("rst_ready0", 32'(req_ready[0]), 0);
    @(posedge clk); #1;

    // Reset while the op is in EXEC: it must vanish without a response.
    set_op(0, 4'd0, 32'd10, 32'd20, 5'd0);
    req_valid[0] = 1'b1;
    wait_ready(0, ok);
    chk("t1_grant", 32'(ok), 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("t1_busy_exec", 32'(busy), 1);
    rst = 1'b1; #1;
    chk("t1_busy_async", 32'(busy), 0);
    chk("t1_rsp0_async", 32'(rsp_valid[0]), 0);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_no_rsp0", 32'(rsp_valid[0]), 0);
      chk("t1_result0", rsp_result[0], 0);
      chk("t1_busy", 32'(busy), 0);
    end
    @(posedge clk); #1;

    // Tie straight out of reset: port 0 first, port 1 follows without a bubble.
    do_reset();
    set_op(0, 4'd1, 32'd5, 32'd7, 5'd0);
    set_op(1, 4'd3, 32'h00010000, 32'h0, 5'd0);
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    @(negedge clk);
    chk("t3_ready0", 32'(req_ready[0]), 1);
    chk("t3_ready1", 32'(req_ready[1]), 0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t3_exec_ready1", 32'(req_ready[1]), 0);
    @(negedge clk);
    chk("t3_rsp0_valid", 32'(rsp_valid[0]), 1);
    chk("t3_rsp0_result", rsp_result[0], 32'hFFFFFFFE);
    chk("t3_ready1_hs", 32'(req_ready[1]), 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t3_rsp1_valid", 32'(rsp_valid[1]), 1);
    chk("t3_rsp1_result", rsp_result[1], 32'd15);
    @(posedge clk); #1;

    // Stalled response holds its value and blocks the other port.
    rsp_ready[1] = 1'b0;
    set_op(1, 4'd4, 32'h0, 32'h80000001, 5'd4);
    req_valid[1] = 1'b1;
    wait_ready(1, ok);
    chk("t4_grant1", 32'(ok), 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_op(0, 4'd0, 32'd3, 32'd4, 5'd0);
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("t4_exec_ready0", 32'(req_ready[0]), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(rsp_valid[1]), 1);
      chk("t4_hold_result", rsp_result[1], 32'h18000000);
      chk("t4_hold_ready0", 32'(req_ready[0]), 0);
    end
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("t4_release_ready0", 32'(req_ready[0]), 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t4_exec_nores", 32'(rsp_valid[0] | rsp_valid[1]), 0);
    @(negedge clk);
    chk("t4_rsp0_result", rsp_result[0], 32'd7);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      run_op(tbl[i].port, tbl[i].ctr, tbl[i].a, tbl[i].b, tbl[i].shamt, tbl[i].exp_r, tbl[i].exp_e,
             $sformatf("vec%0d", i));

    // Both ports streaming with ready tied high.
    do_reset();
    rand_op(0); rand_op(1);
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acc[0] = 1'b0; acc[1] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (rsp_valid[p]) begin
          rc.push_back(c);
          e = (p == 0) ? q0.pop_front() : q1.pop_front();
          chk("t6_result", {31'h0, rsp_err[p]} ^ 32'(e[32]), 0);
          chk("t6_value", rsp_result[p], e[31:0]);
        end
        if (req_ready[p]) begin
          g.push_back(p);
          acc[p] = 1'b1;
          if (p == 0) q0.push_back(model(req_ctr[p], req_a[p], req_b[p], req_shamt[p]));
          else        q1.push_back(model(req_ctr[p], req_a[p], req_b[p], req_shamt[p]));
        end
      end
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) if (acc[p]) rand_op(p);
    end
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    chk("t6_grants", 32'(g.size()), 10);
    foreach (g[i]) chk("t6_order", 32'(g[i]), 32'(i % 2));
    for (int i = 1; i < rc.size(); i++) chk("t6_gap", 32'(rc[i] - rc[i-1]), 2);
    repeat (3) @(posedge clk); #1;
    q0.delete(); q1.delete();

    // Random traffic with random response backpressure.
    do_reset();
    cyc = 0;
    while (cyc < 1200) begin
      @(negedge clk);
      chk("rnd_ready_onehot", 32'(req_ready[0] & req_ready[1]), 0);
      chk("rnd_valid_onehot", 32'(rsp_valid[0] & rsp_valid[1]), 0);
      for (int p = 0; p < 2; p++) begin
        acc[p] = 1'b0;
        if (rsp_valid[p] && rsp_ready[p]) begin
          if ((p == 0 ? q0.size() : q1.size()) == 0) begin
            chk("rnd_unexpected_rsp", 32'(p), 32'(p + 10));
          end else begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rnd_rsp%0d", p), {rsp_err[p], rsp_result[p]} == e ? 32'd1 : 32'd0, 1);
          end
        end
        if (req_valid[p] && req_ready[p]) begin
          acc[p] = 1'b1;
          if (p == 0) q0.push_back(model(req_ctr[p], req_a[p], req_b[p], req_shamt[p]));
          else        q1.push_back(model(req_ctr[p], req_a[p], req_b[p], req_shamt[p]));
        end
      end
      @(posedge clk); #1;
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (acc[p] || !req_valid[p]) begin
          if (cyc < 600 && $urandom_range(0, 2) != 0) begin
            rand_op(p); req_valid[p] = 1'b1;
          end else begin
            req_valid[p] = 1'b0;
          end
        end
        rsp_ready[p] = ($urandom_range(0, 3) != 0);
      end
      if (cyc >= 600 && !req_valid[0] && !req_valid[1] && !busy && q0.size() == 0 && q1.size() == 0)
        break;
    end
    chk("rnd_drain_q0", 32'(q0.size()), 0);
    chk("rnd_drain_q1", 32'(q1.size()), 0);
    chk("rnd_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
